// File: rtl/vpu_src_fetch.sv
// vpu_src_fetch: operand-fetch stage between the VPU request interface and the
// SRAM source-read port. One instruction in flight at a time; its source reads
// are issued serially over a single port and collected into operand registers
// before being handed to the execute stage.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | in_ready high, waiting for an instruction
// REQ       | read request for src[cnt] on the port, held until src_ack
// WAIT_DATA | request accepted, waiting for src_rvalid
// OUT       | operands presented, waiting for out_ready
module vpu_src_fetch #(
    parameter int SRAM_BANK_CNT_LG2   = 4,
    parameter int SRAM_BANK_DEPTH_LG2 = 10,
    parameter int SRAM_DATA_WIDTH     = 512,
    parameter int OPCODE_W            = 8,
    parameter int SRC_W               = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [OPCODE_W-1:0]            in_opcode,
    input  logic [1:0]                     in_num_src,
    input  logic [SRC_W-1:0]               in_src0,
    input  logic [SRC_W-1:0]               in_src1,
    input  logic [SRC_W-1:0]               in_src2,
    input  logic [SRC_W-1:0]               in_dst0,
    output logic                           src_req,
    input  logic                           src_ack,
    output logic [SRAM_BANK_CNT_LG2-1:0]   src_rid,
    output logic [SRAM_BANK_DEPTH_LG2-1:0] src_addr,
    output logic                           src_reb,
    output logic                           src_rlast,
    input  logic [SRAM_DATA_WIDTH-1:0]     src_rdata,
    input  logic                           src_rvalid,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OPCODE_W-1:0]            out_opcode,
    output logic [SRC_W-1:0]               out_dst0,
    output logic [SRAM_DATA_WIDTH-1:0]     out_opnd0,
    output logic [SRAM_DATA_WIDTH-1:0]     out_opnd1,
    output logic [SRAM_DATA_WIDTH-1:0]     out_opnd2
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_OUT       = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic                         r_in_ready;
    logic [OPCODE_W-1:0]          r_opcode;
    logic [1:0]                   r_num_src;
    logic [1:0]                   r_cnt;
    logic [SRC_W-1:0]             r_src0;
    logic [SRC_W-1:0]             r_src1;
    logic [SRC_W-1:0]             r_src2;
    logic [SRC_W-1:0]             r_dst0;
    logic [SRAM_DATA_WIDTH-1:0]   r_opnd0;
    logic [SRAM_DATA_WIDTH-1:0]   r_opnd1;
    logic [SRAM_DATA_WIDTH-1:0]   r_opnd2;

    logic                         w_accept;
    logic                         w_last;
    logic                         w_in_req;
    logic                         w_rdata_take;
    logic [SRC_W-1:0]             w_src_sel;

    assign w_accept     = (r_state == S_IDLE) && in_valid && r_in_ready;
    assign w_last       = (r_cnt == (r_num_src - 2'd1));
    assign w_in_req     = (r_state == S_REQ);
    assign w_rdata_take = (r_state == S_WAIT_DATA) && src_rvalid;

    // Select the source address for the read currently being issued.
    always_comb begin
        w_src_sel = r_src0;
        case (r_cnt)
            2'd0:    w_src_sel = r_src0;
            2'd1:    w_src_sel = r_src1;
            default: w_src_sel = r_src2;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; stray ack/rvalid outside their own state are ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (in_num_src == 2'd0) ? S_OUT : S_REQ;
                end
            end
            S_REQ: begin
                if (src_ack) begin
                    w_state_nxt = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (src_rvalid) begin
                    w_state_nxt = w_last ? S_OUT : S_REQ;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // in_ready is registered: high exactly in cycles spent in IDLE, so it
    // first rises one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == S_IDLE);
        end
    end

    // Latch the instruction on accept; operands are cleared so unfetched
    // slots read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode  <= '0;
            r_num_src <= '0;
            r_src0    <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_dst0    <= '0;
        end else if (w_accept) begin
            r_opcode  <= in_opcode;
            r_num_src <= in_num_src;
            r_src0    <= in_src0;
            r_src1    <= in_src1;
            r_src2    <= in_src2;
            r_dst0    <= in_dst0;
        end
    end

    // Read index and operand collection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_opnd0 <= '0;
            r_opnd1 <= '0;
            r_opnd2 <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_opnd0 <= '0;
            r_opnd1 <= '0;
            r_opnd2 <= '0;
        end else if (w_rdata_take) begin
            case (r_cnt)
                2'd0:    r_opnd0 <= src_rdata;
                2'd1:    r_opnd1 <= src_rdata;
                default: r_opnd2 <= src_rdata;
            endcase
            if (!w_last) begin
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    // Port outputs are decoded from registered state only; the address bus
    // is parked at zero outside REQ.
    assign in_ready   = r_in_ready;
    assign src_req    = w_in_req;
    assign src_reb    = ~w_in_req;
    assign src_rid    = w_in_req ? w_src_sel[SRC_W-1 -: SRAM_BANK_CNT_LG2] : '0;
    assign src_addr   = w_in_req ? w_src_sel[SRAM_BANK_DEPTH_LG2-1:0] : '0;
    assign src_rlast  = w_in_req && w_last;
    assign out_valid  = (r_state == S_OUT);
    assign out_opcode = r_opcode;
    assign out_dst0   = r_dst0;
    assign out_opnd0  = r_opnd0;
    assign out_opnd1  = r_opnd1;
    assign out_opnd2  = r_opnd2;

endmodule

// File: doc/vpu_src_fetch.md
Name: vpu_src_fetch

Overview:
Operand-fetch stage between the VPU request interface and the SRAM source-read port. Accepts one instruction (opcode, up to three source addresses, one destination) per valid/ready handshake. Issues the required SRAM reads one at a time over a single source port, collecting each 512-bit read into an operand register. Presents the opcode, destination and assembled operands to the execute stage over a valid/ready handshake.

Parameters:
SRAM_BANK_CNT_LG2, 4, bank-id width
SRAM_BANK_DEPTH_LG2, 10, word address width within a bank
SRAM_DATA_WIDTH, 512, read data / operand width
OPCODE_W, 8, opcode width
(derived) SRC_W = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2; source field = {bank id, word addr}

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  instruction valid
in_ready  out  1  stage can accept an instruction
in_opcode  in  OPCODE_W  opcode
in_num_src  in  2  number of source operands to fetch, 0..3
in_src0 / in_src1 / in_src2  in  SRC_W each  source addresses
in_dst0  in  SRC_W  destination address, passed through
src_req  out  1  read request
src_ack  in  1  request accepted
src_rid  out  SRAM_BANK_CNT_LG2  bank id
src_addr  out  SRAM_BANK_DEPTH_LG2  word address
src_reb  out  1  read enable, active-low
src_rlast  out  1  last read of this instruction
src_rdata  in  SRAM_DATA_WIDTH  read data
src_rvalid  in  1  read data valid, one-cycle pulse
out_valid  out  1  operands valid
out_ready  in  1  execute stage accepts
out_opcode  out  OPCODE_W  latched opcode
out_dst0  out  SRC_W  latched destination
out_opnd0 / out_opnd1 / out_opnd2  out  SRAM_DATA_WIDTH each  fetched operands

Interface: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.

Behaviour:
- Reset (rst_n=0): state=IDLE, all outputs 0 except src_reb=1, in_ready=0. in_ready is registered and rises on the first clk edge after reset release.
- FSM states: IDLE, REQ, WAIT_DATA, OUT. cnt is 2 bits; last = (cnt == num_src-1).
- IDLE: in_ready=1. On in_valid&in_ready, the stage:
  - latches opcode, num_src, src0..2 and dst0;
  - clears out_opnd0..2 to 0 and sets cnt=0;
  - moves to REQ, or to OUT if num_src==0.
- REQ:
  - src_req=1, src_reb=0.
  - {src_rid,src_addr} = src[cnt]; src_rlast = last.
  - All four outputs stay stable until src_ack is sampled high.
  - On ack the stage moves to WAIT_DATA. src_req=0 and src_reb=1 from the next cycle.
- WAIT_DATA:
  - Waits an unbounded number of cycles for src_rvalid.
  - On rvalid, writes src_rdata into out_opnd[cnt]. If last, moves to OUT; otherwise cnt++ and returns to REQ.
- One outstanding read at a time. src_rvalid in IDLE, REQ or OUT is ignored. src_ack outside REQ is ignored.
- OUT:
  - out_valid=1; out_opcode, out_dst0 and out_opnd0..2 are held stable.
  - Operands at index >= num_src read 0.
  - On out_ready, the stage moves to IDLE. out_valid drops the next cycle.
- Latency:
  - accept at edge T; src_req high in the cycle after T;
  - minimum per-read cost is req->ack 1 cycle plus ack->rvalid of at least 1 cycle;
  - out_valid is asserted the cycle after the last rvalid.
- in_ready=0 in every state except IDLE, so there is no overlap between instructions.
- in_num_src is 2 bits, so it has no out-of-range value.
- Reset asserted mid-transaction aborts immediately to reset values. Partial operands are discarded and no completion is issued.

Test Plan:
- num_src=3, src0={bank 1,addr 0x010}, src1={2,0x020}, src2={3,0x030}; responder acks 1 cycle after req and sends rvalid 5 cycles after ack with data 0xA…, 0xB…, 0xC… → required response:
  - exactly 3 reqs with rid/addr 1/0x010, 2/0x020, 3/0x030;
  - rlast only on the third req;
  - out_opnd0..2 = A, B, C; out_valid 1 cycle after the third rvalid.
- num_src=1, src0={5,0x3FF} → one req with rid=5, addr=0x3FF, rlast=1; out_opnd1 = out_opnd2 = 0.
- num_src=0, opcode 0x12, dst0=0x0ABC → no src_req at all; out_valid the cycle after accept with out_opcode=0x12 and out_dst0=0x0ABC.
- ack delayed 7 cycles and out_ready held low 4 cycles → req/rid/addr stable all 7 cycles and in_ready=0 throughout. out_* are stable while out_valid=1 and out_ready=0. in_ready rises the cycle after out_ready.
- Spurious rvalid pulse in IDLE, plus ack pulses while in WAIT_DATA → no state change and no operand written.
- rst_n asserted during WAIT_DATA of the second read → all outputs return to reset values. After release, a new num_src=2 instruction completes normally with fresh operands.
